izh_step_sequencer: RTL and testbench
=====================================

Name: izh_step_sequencer

Overview:
- Drives one simulation timestep of the Izhikevich neuron array.
- Walks neuron indices 0..N_NEURONS-1 at one neuron per cycle. For each neuron it reads state (v,u), parameters (a,b,c,d) and input current i from memories, and presents them to the 4-stage Izhikevich update core.
- Captures v_prime/u_prime/fired when each result emerges, writes the new state back, and queues the indices of fired neurons in a spike FIFO for the downstream synapse router.
- Sits directly upstream and downstream of the update core.

Parameters:
N_NEURONS, 64, neurons updated per timestep (>=1)
IDX_W, 6, neuron index width, clog2(N_NEURONS)
PIPE_LAT, 4, update-core latency in cycles, inputs to v_prime/u_prime/fired
FIFO_DEPTH, 16, spike FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin timestep; 1-cycle pulse
busy  out  1  timestep in progress
done  out  1  1-cycle pulse at timestep end
mem_rd_en  out  1  read strobe, common to state/param/current memories
mem_rd_addr  out  IDX_W  neuron index being read
st_rd_data  in  34  {v,u}, valid 1 cycle after mem_rd_en
par_rd_data  in  68  {a,b,c,d}, valid 1 cycle after mem_rd_en
cur_rd_data  in  17  i, valid 1 cycle after mem_rd_en
core_a, core_b, core_c, core_d, core_v, core_u, core_i  out  17 each  update-core operands
core_v_prime, core_u_prime  in  17 each  update-core results
core_fired  in  1  update-core spike flag
st_wr_en  out  1  state write-back strobe
st_wr_addr  out  IDX_W  write-back index
st_wr_data  out  34  {v_prime,u_prime}
spk_valid  out  1  spike FIFO head valid
spk_idx  out  IDX_W  fired neuron index
spk_ts  out  16  timestep stamp (see Optional Feature)
spk_ready  in  1  downstream accepts head
spk_overflow  out  1  sticky: a spike was dropped
spike_count  out  IDX_W+1  spikes seen this timestep

Behaviour:
- Data format: 17-bit sign-magnitude Q8.8; bit16 sign, [15:8] integer, [7:0] fraction. The block moves data only; it performs no arithmetic on v/u.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, st_wr_en=0, spk_valid=0, spk_overflow=0, spike_count=0, FIFO empty, FSM=IDLE, tag pipeline cleared.
- FSM states and transitions:
  - IDLE: start -> ISSUE; spike_count cleared.
  - ISSUE: mem_rd_en=1, mem_rd_addr increments 0..N_NEURONS-1, one per cycle. After the last index -> DRAIN.
  - DRAIN: waits until the tag pipeline is empty -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Timeline, with start sampled in cycle 0:
  - Reads occur in cycles 1..N.
  - Core operands are driven combinationally from the read data in cycles 2..N+1.
  - Results arrive in cycles 2+PIPE_LAT..N+1+PIPE_LAT.
  - done is asserted in cycle N+2+PIPE_LAT.
  - busy is high in cycles 1..N+1+PIPE_LAT.
- Core operands are don't-care when no read data is valid.
- Tag pipeline: valid bit plus index, length PIPE_LAT+1, shifts every cycle. The core has no stall, so the sequencer never stalls.
- Write-back: when the tag output is valid, assert st_wr_en with st_wr_addr=tag index and st_wr_data={core_v_prime,core_u_prime}. Core outputs are ignored when the tag is invalid.
- Spikes: when the tag is valid and core_fired=1, spike_count increments (saturates at N_NEURONS) and the index is pushed to the FIFO.
- FIFO:
  - Pop occurs when spk_valid && spk_ready.
  - Push when full: the spike is dropped and spk_overflow is set; spk_overflow clears only on rst.
  - Push and pop in the same cycle while full: the pop frees the slot and the push succeeds.
  - The FIFO is first-word-fall-through; spk_idx/spk_ts are stable while spk_valid && !spk_ready.
- start while busy, or in the DONE cycle, is ignored.
- rst mid-operation: next cycle is IDLE with no further st_wr_en, tag pipeline flushed, FIFO emptied.

Optional Feature:
- Macro: IZH_SPIKE_TIMESTAMP_EN.
- Defined: a 16-bit timestep counter (reset 0) increments in the DONE cycle and wraps at 0xFFFF->0. Each FIFO entry stores {idx, counter value at push}, and spk_ts presents the stored value.
- Undefined: no counter and no timestamp storage; spk_ts is tied to 0.

Test Plan:
1. N_NEURONS=4, PIPE_LAT=4, start at cycle 0 -> mem_rd_addr 0,1,2,3 in cycles 1-4; st_wr_en in cycles 6-9 with addrs 0-3; done in cycle 10; busy in cycles 1-9.
2. Core model (4-cycle delay) fires only for idx 2 with v_prime=0x14100 (-65.0) -> one spike entry idx=2; spike_count=1; st_wr_data for addr 2 = {0x14100, core_u_prime}.
3. N=64, all fire, spk_ready=0, FIFO_DEPTH=16 -> 16 entries idx 0..15, spk_overflow=1, spike_count=64; then spk_ready=1 drains exactly 16 entries in order.
4. start pulsed again in cycles 3 and 10 (done cycle) of a run -> both ignored; no second timestep begins.
5. rst asserted in cycle 5 of an N=8 run -> from cycle 6: st_wr_en=0, busy=0, spk_valid=0, no done pulse.
6. With IZH_SPIKE_TIMESTAMP_EN, two timesteps each firing idx 1 -> spk_ts=0 then spk_ts=1. Without the macro -> spk_ts=0 for both.

Source files
------------

// File: rtl/izh_step_sequencer_if.sv
// rtl/izh_step_sequencer_if.sv - spike FIFO output stream between the step sequencer and the synapse router
interface izh_step_sequencer_if #(
  parameter int IDX_W = 6
) ();
  logic             spk_valid;
  logic [IDX_W-1:0] spk_idx;
  logic [15:0]      spk_ts;
  logic             spk_ready;

  modport master (output spk_valid, spk_idx, spk_ts, input spk_ready);
  modport slave  (input spk_valid, spk_idx, spk_ts, output spk_ready);
endinterface

// File: rtl/izh_step_sequencer.sv
// rtl/izh_step_sequencer.sv - walks one Izhikevich timestep: read, feed update core, write back, queue spikes
// Optional macro IZH_SPIKE_TIMESTAMP_EN stamps each queued spike with a 16-bit timestep counter.
module izh_step_sequencer #(
  parameter int N_NEURONS  = 64,
  parameter int IDX_W      = 6,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [IDX_W-1:0]     mem_rd_addr,
  input  logic [33:0]          st_rd_data,
  input  logic [67:0]          par_rd_data,
  input  logic [16:0]          cur_rd_data,
  output logic [16:0]          core_a,
  output logic [16:0]          core_b,
  output logic [16:0]          core_c,
  output logic [16:0]          core_d,
  output logic [16:0]          core_v,
  output logic [16:0]          core_u,
  output logic [16:0]          core_i,
  input  logic [16:0]          core_v_prime,
  input  logic [16:0]          core_u_prime,
  input  logic                 core_fired,
  output logic                 st_wr_en,
  output logic [IDX_W-1:0]     st_wr_addr,
  output logic [33:0]          st_wr_data,
  izh_step_sequencer_if.master spk,
  output logic                 spk_overflow,
  output logic [IDX_W:0]       spike_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       addr_q, addr_d;
  logic [PIPE_LAT:0]      tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]       tag_idx_q [PIPE_LAT+1];
  logic [IDX_W-1:0]       tag_idx_d [PIPE_LAT+1];
  logic [IDX_W:0]         spike_count_q, spike_count_d;
  logic [IDX_W-1:0]       fifo_idx_q [FIFO_DEPTH];
  logic [IDX_W-1:0]       fifo_idx_d [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d;

  logic                   wb_vld, wb_fire, fifo_empty, fifo_full, pop, push_ok;
  logic [IDX_W-1:0]       wb_idx;

  // Operands come straight off the read ports; tag stage 0 lines up with them.
  assign core_v = st_rd_data[33:17];
  assign core_u = st_rd_data[16:0];
  assign core_a = par_rd_data[67:51];
  assign core_b = par_rd_data[50:34];
  assign core_c = par_rd_data[33:17];
  assign core_d = par_rd_data[16:0];
  assign core_i = cur_rd_data;

  assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign mem_rd_en   = (state_q == S_ISSUE);
  assign mem_rd_addr = addr_q;

  assign wb_vld     = tag_vld_q[PIPE_LAT];
  assign wb_idx     = tag_idx_q[PIPE_LAT];
  assign wb_fire    = wb_vld && core_fired;
  assign st_wr_en   = wb_vld;
  assign st_wr_addr = wb_idx;
  assign st_wr_data = {core_v_prime, core_u_prime};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (PTR_W+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && spk.spk_ready;
  assign push_ok    = wb_fire && (!fifo_full || pop);

  assign spk.spk_valid = !fifo_empty;
  assign spk.spk_idx   = fifo_idx_q[rd_ptr_q[PTR_W-1:0]];
  assign spk_overflow  = ovf_q;
  assign spike_count   = spike_count_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        if (addr_q == IDX_W'(N_NEURONS - 1)) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + IDX_W'(1);
        end
      end
      // Leave one cycle early so done lands right after the final write-back.
      S_DRAIN: begin
        if (tag_vld_q[PIPE_LAT-1:0] == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tag_vld_d    = {tag_vld_q[PIPE_LAT-1:0], mem_rd_en};
    tag_idx_d    = tag_idx_q;
    tag_idx_d[0] = addr_q;
    for (int k = 1; k <= PIPE_LAT; k++) tag_idx_d[k] = tag_idx_q[k-1];

    spike_count_d = spike_count_q;
    if (state_q == S_IDLE && start) spike_count_d = '0;
    else if (wb_fire && spike_count_q != (IDX_W+1)'(N_NEURONS))
      spike_count_d = spike_count_q + (IDX_W+1)'(1);
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  always_comb begin
    fifo_idx_d = fifo_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    if (push_ok) begin
      fifo_idx_d[wr_ptr_q[PTR_W-1:0]] = wb_idx;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (wb_fire && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      tag_vld_q     <= '0;
      tag_idx_q     <= '{default: '0};
      spike_count_q <= '0;
      fifo_idx_q    <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      tag_vld_q     <= tag_vld_d;
      tag_idx_q     <= tag_idx_d;
      spike_count_q <= spike_count_d;
      fifo_idx_q    <= fifo_idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ovf_q         <= ovf_d;
    end
  end

`ifdef IZH_SPIKE_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_cnt_d;
  logic [15:0] fifo_ts_q [FIFO_DEPTH];
  logic [15:0] fifo_ts_d [FIFO_DEPTH];

  always_comb begin
    ts_cnt_d  = ts_cnt_q + ((state_q == S_DONE) ? 16'd1 : 16'd0);
    fifo_ts_d = fifo_ts_q;
    if (push_ok) fifo_ts_d[wr_ptr_q[PTR_W-1:0]] = ts_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      fifo_ts_q <= '{default: '0};
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      fifo_ts_q <= fifo_ts_d;
    end
  end

  assign spk.spk_ts = fifo_ts_q[rd_ptr_q[PTR_W-1:0]];
`else
  assign spk.spk_ts = 16'h0000;
`endif

endmodule

// File: tb/tb_izh_step_sequencer.sv
// tb/tb_izh_step_sequencer.sv - randomized self-checking bench for izh_step_sequencer (N=8, FIFO depth 4)
module tb_izh_step_sequencer;
  localparam int N     = 8;
  localparam int IW    = 3;
  localparam int PL    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic          busy, done, mem_rd_en, st_wr_en, spk_overflow, core_fired;
  logic [IW-1:0] mem_rd_addr, st_wr_addr;
  logic [IW:0]   spike_count;
  logic [33:0]   st_rd_data, st_wr_data;
  logic [67:0]   par_rd_data;
  logic [16:0]   cur_rd_data, core_v_prime, core_u_prime;
  logic [16:0]   core_a, core_b, core_c, core_d, core_v, core_u, core_i;

  izh_step_sequencer_if #(.IDX_W(IW)) spk_if ();

  izh_step_sequencer #(.N_NEURONS(N), .IDX_W(IW), .PIPE_LAT(PL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .st_rd_data(st_rd_data), .par_rd_data(par_rd_data), .cur_rd_data(cur_rd_data),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_v(core_v), .core_u(core_u), .core_i(core_i),
    .core_v_prime(core_v_prime), .core_u_prime(core_u_prime), .core_fired(core_fired),
    .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr), .st_wr_data(st_wr_data),
    .spk(spk_if.master), .spk_overflow(spk_overflow), .spike_count(spike_count)
  );

  // Memories with one-cycle read latency.
  logic [33:0] st_mem  [N];
  logic [67:0] par_mem [N];
  logic [16:0] cur_mem [N];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      st_rd_data  <= st_mem[mem_rd_addr];
      par_rd_data <= par_mem[mem_rd_addr];
      cur_rd_data <= cur_mem[mem_rd_addr];
    end
  end

  // Update core stand-in: fixed PL-cycle delay, v'=v^i, u'=u^a, fires on i[0].
  logic [16:0] pv [PL];
  logic [16:0] pu [PL];
  logic        pf [PL];
  always @(posedge clk) begin
    pv[0] <= core_v ^ core_i;
    pu[0] <= core_u ^ core_a;
    pf[0] <= core_i[0];
    for (int k = 1; k < PL; k++) begin
      pv[k] <= pv[k-1];
      pu[k] <= pu[k-1];
      pf[k] <= pf[k-1];
    end
  end
  assign core_v_prime = pv[PL-1];
  assign core_u_prime = pu[PL-1];
  assign core_fired   = pf[PL-1];

  int checks = 0;
  int errors = 0;

  int   q_idx[$];
  int   q_ts[$];
  logic ovf_m = 1'b0;
  int   ts_m  = 0;
  int   sc_m  = 0;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ts_expect();
`ifdef IZH_SPIKE_TIMESTAMP_EN
    return ts_m & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  // Compare the FIFO head this cycle, then apply the pop/push the coming edge will perform.
  task automatic fifo_cycle(input logic rdy, input logic push, input int idx);
    chk("spk_valid", spk_if.spk_valid, q_idx.size() > 0);
    if (q_idx.size() > 0) begin
      chk("spk_idx", spk_if.spk_idx, q_idx[0]);
      chk("spk_ts", spk_if.spk_ts, q_ts[0]);
    end
    chk("spk_overflow", spk_overflow, ovf_m);
    if (rdy && q_idx.size() > 0) begin
      void'(q_idx.pop_front());
      void'(q_ts.pop_front());
    end
    if (push) begin
      if (q_idx.size() < DEPTH) begin
        q_idx.push_back(idx);
        q_ts.push_back(ts_expect());
      end else begin
        ovf_m = 1'b1;
      end
    end
  endtask

  task automatic run_step(input logic [N-1:0] fire, input logic rdy);
    int          j;
    logic        wr;
    logic [33:0] exp_wd;
    for (int n = 0; n < N; n++) begin
      st_mem[n]  = 34'({$urandom(), $urandom()});
      par_mem[n] = 68'({$urandom(), $urandom(), $urandom()});
      cur_mem[n] = {16'($urandom()), fire[n]};
    end
    for (int c = 0; c <= N + 4 + PL; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0) || (c == 3) || (c == N + 2 + PL);
      spk_if.spk_ready = rdy;
      @(negedge clk);
      wr = (c >= 2 + PL) && (c <= N + 1 + PL);
      j  = c - 2 - PL;
      chk("busy", busy, (c >= 1) && (c <= N + 1 + PL));
      chk("done", done, c == N + 2 + PL);
      chk("mem_rd_en", mem_rd_en, (c >= 1) && (c <= N));
      if (c >= 1 && c <= N) chk("mem_rd_addr", mem_rd_addr, c - 1);
      chk("st_wr_en", st_wr_en, wr);
      if (wr) begin
        exp_wd = {st_mem[j][33:17] ^ cur_mem[j], st_mem[j][16:0] ^ par_mem[j][67:51]};
        chk("st_wr_addr", st_wr_addr, j);
        chk("st_wr_data", st_wr_data, exp_wd);
      end
      chk("spike_count", spike_count, sc_m);
      fifo_cycle(rdy, wr && fire[j], j);
      if (c == 0) sc_m = 0;
      if (wr && fire[j]) sc_m++;
      if (c == N + 2 + PL) ts_m++;
    end
  endtask

  task automatic drain();
    logic r;
    for (int k = 0; k < 40 && q_idx.size() > 0; k++) begin
      @(posedge clk);
      #1;
      r = (k >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      spk_if.spk_ready = r;
      @(negedge clk);
      fifo_cycle(r, 1'b0, 0);
    end
    @(posedge clk);
    #1;
    spk_if.spk_ready = 1'b0;
    @(negedge clk);
    fifo_cycle(1'b0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    spk_if.spk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_st_wr_en", st_wr_en, 1'b0);
    chk("rst_spk_valid", spk_if.spk_valid, 1'b0);
    chk("rst_spk_overflow", spk_overflow, 1'b0);
    chk("rst_spike_count", spike_count, 0);

    run_step(8'b0000_0100, 1'b0);
    drain();
    run_step(8'hFF, 1'b0);
    run_step(8'hFF, 1'b1);
    drain();
    repeat (3) run_step(N'($urandom()), 1'($urandom_range(0, 1)));
    drain();

    run_step(8'b0101_0101, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0);
      rst   = (c == 5);
    end
    q_idx.delete();
    q_ts.delete();
    ovf_m = 1'b0;
    ts_m  = 0;
    sc_m  = 0;
    for (int c = 6; c <= 14; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_st_wr_en", st_wr_en, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_spk_valid", spk_if.spk_valid, 1'b0);
      chk("mid_rst_spike_count", spike_count, 0);
    end

    run_step(8'b0000_0010, 1'b0);
    run_step(8'b0000_0010, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
